// File: rtl/spectro_acq_ctrl_pkg.sv
// Shared types and default sizing for the spectrometer frame sequencer.
// Contents: acq_state_t (sequencer states), NUM_CH (channel readers),
// default bin count, row length and bin word width.
package spectro_pkg;

  localparam int NUM_CH         = 4;
  localparam int DEF_NUM_BINS   = 1280;
  localparam int DEF_ROW_PIXELS = 1280;
  localparam int DEF_BIN_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACQ,
    DRAIN,
    READOUT
  } acq_state_t;

endpackage

// File: rtl/spectro_acq_ctrl_if.sv
// Bin readout stream (valid/ready).
// master: drives out_valid, out_data, out_last; samples out_ready.
// slave : the consumer side.
interface spectro_acq_ctrl_if
  import spectro_pkg::*;
#(
  parameter int BIN_DATA_W = DEF_BIN_DATA_W
);
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_DATA_W-1:0] out_data;
  logic                  out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/spectro_row_tracker.sv
// Per-channel pixel counting for one sensor row.
// Ports: clk, rst (async, active-high); clr restarts all counters; en gates
// counting (acquisition window); pixValid per-channel accepted-pixel strobes;
// rowDone pulses in the cycle all four channels reach a full row;
// overrunHit pulses when a full channel strobes outside a completion cycle.
module spectro_row_tracker
  import spectro_pkg::*;
#(
  parameter int ROW_PIXELS = DEF_ROW_PIXELS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [NUM_CH-1:0] pixValid,
  output logic              rowDone,
  output logic              overrunHit
);

  localparam int PER_CH = ROW_PIXELS / NUM_CH;
  localparam int CNT_W  = $clog2(PER_CH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PER_CH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PER_CH - 1);

  logic [CNT_W-1:0]  pixCnt [NUM_CH];
  logic [NUM_CH-1:0] full, hit, reach;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      full[i]  = (pixCnt[i] == FULL_CNT);
      hit[i]   = en && pixValid[i];
      // Reaches the row end either already or with this cycle's strobe.
      reach[i] = full[i] || (hit[i] && (pixCnt[i] == LAST_CNT));
    end
  end

  assign rowDone    = en && (&reach);
  assign overrunHit = (|(hit & full)) && !rowDone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) pixCnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CH; i++) pixCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rowDone) begin
          // A strobe on an already-full channel opens the next row.
          pixCnt[i] <= (full[i] && hit[i]) ? CNT_W'(1) : '0;
        end else if (hit[i] && !full[i]) begin
          pixCnt[i] <= pixCnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spectro_acq_ctrl.sv
// Frame sequencer for the four-channel binning datapath:
// IDLE -> CLEAR (zero bin memory) -> ACQ (readers enabled for the programmed
// row count) -> DRAIN (wait for quiet strobes) -> READOUT (stream bins) -> IDLE.
// Ports: clk, rst (async, active-high); start/abort control; num_rows_cfg rows
// per frame (0 means 1); chan_ena/pix_valid per-channel reader control and
// strobes; acc_en accumulate enable; clr_we/clr_addr memory clear;
// rd_en/rd_addr/rd_data memory read (data one cycle after rd_en);
// strm bin output stream; busy/done/row_cnt/overrun_err status.
module spectro_acq_ctrl
  import spectro_pkg::*;
#(
  parameter int NUM_BINS   = DEF_NUM_BINS,
  parameter int ROW_PIXELS = DEF_ROW_PIXELS,
  parameter int BIN_DATA_W = DEF_BIN_DATA_W,
  parameter int DRAIN_CYC  = 16,
  localparam int ADDR_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [10:0]             num_rows_cfg,
  output logic [NUM_CH-1:0]       chan_ena,
  input  logic [NUM_CH-1:0]       pix_valid,
  output logic                    acc_en,
  output logic                    clr_we,
  output logic [ADDR_W-1:0]       clr_addr,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [BIN_DATA_W-1:0]   rd_data,
  spectro_acq_ctrl_if.master      strm,
  output logic                    busy,
  output logic                    done,
  output logic [10:0]             row_cnt,
  output logic                    overrun_err
);

  localparam int IDX_W   = $clog2(NUM_BINS + 1);
  localparam int QUIET_W = $clog2(DRAIN_CYC + 1);
  localparam logic [IDX_W-1:0]   BINS      = IDX_W'(NUM_BINS);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_BINS - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_BINS - 1);
  localparam logic [QUIET_W-1:0] QUIET_END = QUIET_W'(DRAIN_CYC - 1);

  acq_state_t            state;
  logic [ADDR_W-1:0]     clrAddr;
  logic [10:0]           rowCnt, rowTarget;
  logic [QUIET_W-1:0]    quietCnt;
  logic                  overrunErr, doneR;
  logic [IDX_W-1:0]      rdIssued, outIdx;
  logic                  rdVld_p1;
  logic [BIN_DATA_W-1:0] skidData [2];
  logic                  skidWr, skidRd;
  logic [1:0]            skidCnt, occ;
  logic                  rowDone, overrunHit, outValid, pop, issue;

  spectro_row_tracker #(.ROW_PIXELS(ROW_PIXELS)) uTracker (
    .clk        (clk),
    .rst        (rst),
    .clr        (state == IDLE && start && !abort),
    .en         (state == ACQ),
    .pixValid   (pix_valid),
    .rowDone    (rowDone),
    .overrunHit (overrunHit)
  );

  assign outValid = (skidCnt != 2'd0);
  assign pop      = outValid && strm.out_ready;
  // Skid occupancy once this cycle's read lands and this cycle's beat leaves.
  assign occ      = skidCnt + {1'b0, rdVld_p1} - {1'b0, pop};
  assign issue    = (state == READOUT) && !abort && (rdIssued != BINS) && (occ < 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clrAddr    <= '0;
      rowCnt     <= '0;
      rowTarget  <= '0;
      quietCnt   <= '0;
      overrunErr <= 1'b0;
      doneR      <= 1'b0;
      rdIssued   <= '0;
      outIdx     <= '0;
    end else begin
      doneR <= 1'b0;
      if (overrunHit) overrunErr <= 1'b1;
      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            state      <= CLEAR;
            clrAddr    <= '0;
            rowCnt     <= '0;
            rowTarget  <= (num_rows_cfg == 11'd0) ? 11'd1 : num_rows_cfg;
            overrunErr <= 1'b0;
          end
          CLEAR: begin
            if (clrAddr == LAST_ADDR) state <= ACQ;
            else clrAddr <= clrAddr + 1'b1;
          end
          ACQ: if (rowDone) begin
            rowCnt <= rowCnt + 11'd1;
            if (rowCnt + 11'd1 == rowTarget) begin
              state    <= DRAIN;
              quietCnt <= '0;
            end
          end
          DRAIN: begin
            if (|pix_valid) quietCnt <= '0;
            else if (quietCnt == QUIET_END) begin
              state    <= READOUT;
              rdIssued <= '0;
              outIdx   <= '0;
            end else quietCnt <= quietCnt + 1'b1;
          end
          READOUT: begin
            if (issue) rdIssued <= rdIssued + 1'b1;
            if (pop) begin
              outIdx <= outIdx + 1'b1;
              if (outIdx == LAST_IDX) begin
                state <= IDLE;
                doneR <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Stage p0 -> p1: read issued, memory returns data one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdVld_p1 <= 1'b0;
      skidWr   <= 1'b0;
      skidRd   <= 1'b0;
      skidCnt  <= 2'd0;
    end else if (abort || state != READOUT) begin
      rdVld_p1 <= 1'b0;
      skidWr   <= 1'b0;
      skidRd   <= 1'b0;
      skidCnt  <= 2'd0;
    end else begin
      rdVld_p1 <= issue;
      if (rdVld_p1) skidWr <= ~skidWr;
      if (pop) skidRd <= ~skidRd;
      skidCnt <= occ;
    end
  end

  // Stage p1 -> skid: capture returned bin words.
  always_ff @(posedge clk) begin
    if (rdVld_p1) skidData[skidWr] <= rd_data;
  end

  assign busy           = (state != IDLE);
  assign chan_ena       = (state == ACQ) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};
  assign acc_en         = (state == ACQ) || (state == DRAIN);
  assign clr_we         = (state == CLEAR);
  assign clr_addr       = clrAddr;
  assign rd_en          = issue;
  assign rd_addr        = rdIssued[ADDR_W-1:0];
  assign strm.out_valid = outValid;
  assign strm.out_data  = outValid ? skidData[skidRd] : '0;
  assign strm.out_last  = outValid && (outIdx == LAST_IDX);
  assign done           = doneR;
  assign row_cnt        = rowCnt;
  assign overrun_err    = overrunErr;

endmodule

// File: tb/tb_spectro_acq_ctrl.sv
module tb_spectro_acq_ctrl;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [10:0] num_rows_cfg;
  logic [3:0]  chan_ena, pix_valid;
  logic        acc_en, clr_we, rd_en, busy, done, overrun_err;
  logic [2:0]  clr_addr, rd_addr;
  logic [31:0] rd_data;
  logic [10:0] row_cnt;

  spectro_acq_ctrl_if #(.BIN_DATA_W(32)) ifc ();

  spectro_acq_ctrl #(.NUM_BINS(NB), .ROW_PIXELS(8), .BIN_DATA_W(32), .DRAIN_CYC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_rows_cfg(num_rows_cfg),
    .chan_ena(chan_ena), .pix_valid(pix_valid), .acc_en(acc_en), .clr_we(clr_we),
    .clr_addr(clr_addr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .strm(ifc), .busy(busy), .done(done), .row_cnt(row_cnt), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expBins [NB];
  logic [31:0] gotBeat [NB];
  logic [31:0] mem [NB];
  int          readyMode = 0;
  int          rdyStep = 0;
  int          stallCnt = 0;
  int          n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Bin memory plus a toy datapath: garbage on a new frame, zeroed by the clear
  // sweep, channel c adds c+1 to bin c per strobe while acc_en is high.
  always @(posedge clk) begin
    if (rst || (start && !busy)) begin
      for (int i = 0; i < NB; i++) mem[i] <= 32'hA5A5_0000 + i;
    end else begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (clr_we) mem[clr_addr] <= 32'd0;
      if (acc_en)
        for (int c = 0; c < 4; c++)
          if (pix_valid[c]) mem[c] <= mem[c] + 32'(c + 1);
    end
  end

  // Consumer ready: always high, or 1010... with a 5-cycle stall every 16 cycles.
  always @(posedge clk) begin
    #1;
    if (readyMode == 0) begin
      rdyStep = 0;
      ifc.out_ready = 1'b1;
    end else begin
      rdyStep++;
      ifc.out_ready = ((rdyStep % 16) >= 6 && (rdyStep % 16) < 11) ? 1'b0 : ~rdyStep[0];
    end
  end

  // Reference checker: clear sweep order/length, stream order and stability,
  // done exactly one cycle after the last beat's handshake.
  int          clrIdx = 0, beatIdx = 0;
  logic        prevStall = 1'b0, expDone = 1'b0, prevLast;
  logic [31:0] prevData;
  always @(negedge clk) begin
    if (rst) begin
      clrIdx = 0; beatIdx = 0; prevStall = 1'b0; expDone = 1'b0;
    end else begin
      if (clr_we) begin
        chk("clr_addr", 32'(clr_addr), 32'(clrIdx));
        clrIdx++;
      end else if (clrIdx != 0) begin
        chk("clr_len", 32'(clrIdx), NB);
        clrIdx = 0;
      end
      chk("done_pulse", 32'(done), 32'(expDone));
      expDone = 1'b0;
      if (prevStall) begin
        chk("stall_valid", 32'(ifc.out_valid), 32'd1);
        chk("stall_data", ifc.out_data, prevData);
        chk("stall_last", 32'(ifc.out_last), 32'(prevLast));
      end
      if (ifc.out_valid && ifc.out_ready) begin
        chk("beat_data", ifc.out_data, expBins[beatIdx]);
        chk("beat_last", 32'(ifc.out_last), 32'(beatIdx == NB - 1));
        gotBeat[beatIdx] = ifc.out_data;
        if (beatIdx == NB - 1) begin
          expDone = 1'b1;
          beatIdx = 0;
        end else beatIdx++;
      end else if (!busy) beatIdx = 0;
      prevStall = ifc.out_valid && !ifc.out_ready;
      prevData  = ifc.out_data;
      prevLast  = ifc.out_last;
      if (prevStall) stallCnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [3:0] mask);
    pix_valid = mask;
    for (int c = 0; c < 4; c++) if (mask[c]) expBins[c] = expBins[c] + 32'(c + 1);
    tick();
    pix_valid = 4'h0;
  endtask

  task automatic startFrame(input logic [10:0] cfg);
    for (int i = 0; i < NB; i++) expBins[i] = 32'd0;
    start = 1'b1;
    num_rows_cfg = cfg;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < budget) begin
      tick();
      cnt++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_rows_cfg = 11'd0; pix_valid = 4'h0;
    for (int i = 0; i < NB; i++) expBins[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_chan_ena", 32'(chan_ena), 0);
    chk("rst_acc_en", 32'(acc_en), 0);
    chk("rst_clr_we", 32'(clr_we), 0);
    chk("rst_clr_addr", 32'(clr_addr), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_out_valid", 32'(ifc.out_valid), 0);
    chk("rst_out_data", ifc.out_data, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_row_cnt", 32'(row_cnt), 0);
    chk("rst_overrun", 32'(overrun_err), 0);
    rst = 1'b0;
    tick();

    // Basic frame: 2 rows, ready held high.
    startFrame(11'd2);
    chk("s1_clr_we", 32'(clr_we), 1);
    chk("s1_busy", 32'(busy), 1);
    repeat (8) tick();
    chk("s1_chan_ena", 32'(chan_ena), 32'hF);
    chk("s1_acc_en", 32'(acc_en), 1);
    chk("s1_clr_off", 32'(clr_we), 0);
    pix(4'hF); pix(4'hF);
    chk("s1_row1", 32'(row_cnt), 1);
    pix(4'hF); pix(4'hF);
    chk("s1_row2", 32'(row_cnt), 2);
    chk("s1_drain_ena", 32'(chan_ena), 0);
    chk("s1_drain_acc", 32'(acc_en), 1);
    repeat (3) tick();
    chk("s1_drain_hold", 32'(acc_en), 1);
    tick();
    chk("s1_readout_acc", 32'(acc_en), 0);
    chk("s1_readout_busy", 32'(busy), 1);
    tick(); tick();
    chk("s1_first_valid", 32'(ifc.out_valid), 1);
    waitDone(20, n);
    chk("s1_rate", 32'(n <= 8), 1);
    chk("s1_idle", 32'(busy), 0);
    tick();
    chk("s1_done_once", 32'(done), 0);
    chk("s1_bin0", gotBeat[0], 32'd4);
    chk("s1_bin3", gotBeat[3], 32'd16);
    chk("s1_bin7", gotBeat[7], 32'd0);

    // Stalling consumer, staggered channels, 1 row.
    readyMode = 1;
    startFrame(11'd1);
    repeat (8) tick();
    pix(4'b0011); pix(4'b1100);
    chk("s2_row_pending", 32'(row_cnt), 0);
    pix(4'hF);
    chk("s2_row1", 32'(row_cnt), 1);
    waitDone(80, n);
    chk("s2_bin1", gotBeat[1], 32'd4);
    chk("s2_bin2", gotBeat[2], 32'd6);
    chk("s2_stalls_seen", 32'(stallCnt > 0), 1);
    readyMode = 0;
    tick();

    // Overrun on channel 2.
    startFrame(11'd1);
    repeat (8) tick();
    pix(4'hF); pix(4'b0100);
    chk("s3_no_ovr_yet", 32'(overrun_err), 0);
    pix(4'b0100);
    chk("s3_ovr", 32'(overrun_err), 1);
    chk("s3_row_pending", 32'(row_cnt), 0);
    pix(4'b1011);
    chk("s3_row1", 32'(row_cnt), 1);
    waitDone(40, n);
    chk("s3_bin2", gotBeat[2], 32'd9);
    chk("s3_ovr_sticky", 32'(overrun_err), 1);
    tick();

    // Completion cycle carrying a next-row strobe on channel 0.
    startFrame(11'd2);
    chk("s4_ovr_cleared", 32'(overrun_err), 0);
    repeat (8) tick();
    pix(4'hF); pix(4'b0111); pix(4'b1001);
    chk("s4_row1", 32'(row_cnt), 1);
    chk("s4_no_ovr", 32'(overrun_err), 0);
    pix(4'hF);
    chk("s4_row_pending", 32'(row_cnt), 1);
    pix(4'b1110);
    chk("s4_row2", 32'(row_cnt), 2);
    chk("s4_no_ovr2", 32'(overrun_err), 0);
    waitDone(40, n);
    chk("s4_bin0", gotBeat[0], 32'd4);
    tick();

    // Abort in ACQ, then a fresh frame.
    startFrame(11'd3);
    repeat (8) tick();
    pix(4'hF); pix(4'hF);
    chk("s5_row1", 32'(row_cnt), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s5_ena_off", 32'(chan_ena), 0);
    chk("s5_idle", 32'(busy), 0);
    chk("s5_acc_off", 32'(acc_en), 0);
    chk("s5_row_held", 32'(row_cnt), 1);
    repeat (4) tick();
    startFrame(11'd1);
    chk("s5_clr_again", 32'(clr_we), 1);
    chk("s5_clr_addr0", 32'(clr_addr), 0);
    chk("s5_row_reset", 32'(row_cnt), 0);
    repeat (8) tick();
    pix(4'hF); pix(4'hF);
    waitDone(40, n);
    tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_beats_start", 32'(busy), 0);

    // cfg 0 means 1 row; start during readout is ignored.
    startFrame(11'd0);
    repeat (8) tick();
    pix(4'hF); pix(4'hF);
    chk("s6_row1", 32'(row_cnt), 1);
    n = 0;
    while (acc_en && n < 20) begin
      tick();
      n++;
    end
    chk("s6_readout", 32'(acc_en), 0);
    tick(); tick();
    start = 1'b1; num_rows_cfg = 11'd5;
    tick();
    start = 1'b0;
    chk("s6_start_ignored", 32'(busy), 1);
    chk("s6_no_clear", 32'(clr_we), 0);
    waitDone(40, n);
    chk("s6_rows", 32'(row_cnt), 1);
    chk("s6_bin1", gotBeat[1], 32'd4);
    tick();
    chk("s6_stay_idle", 32'(busy), 0);

    // Reset mid-acquisition.
    startFrame(11'd2);
    repeat (8) tick();
    pix(4'hF);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ena", 32'(chan_ena), 0);
    chk("mid_rst_acc", 32'(acc_en), 0);
    chk("mid_rst_rows", 32'(row_cnt), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spectro_acq_ctrl.md
Name: spectro_acq_ctrl

Overview:
- Frame sequencer for the four-channel spectrometer binning datapath.
- Clears the bin memory, then enables the four channel readers for a programmed number of rows.
- Tracks row completion from per-channel pixel strobes and waits for in-flight data to drain.
- Streams the accumulated bins out over a valid/ready interface.

Parameters:
- NUM_BINS, 1280: bins in memory, 1..1280.
- ROW_PIXELS, 1280: pixels per sensor row; must be divisible by 4.
- BIN_DATA_W, 32: bin word width.
- DRAIN_CYC, 16: consecutive quiet cycles that end DRAIN.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle acquisition request
- abort  in  1  abandon current operation
- num_rows_cfg  in  11  rows per frame; sampled on accepted start; 0 is treated as 1
- chan_ena  out  4  per-channel ENA to readers
- pix_valid  in  4  per-channel accepted-pixel strobe (dataValid)
- acc_en  out  1  datapath may accumulate
- clr_we  out  1  zero-write strobe to bin memory
- clr_addr  out  clog2(NUM_BINS)  clear address
- rd_en  out  1  bin memory read strobe
- rd_addr  out  clog2(NUM_BINS)  read address
- rd_data  in  BIN_DATA_W  bin data, valid 1 cycle after rd_en
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_data  out  BIN_DATA_W  bin value
- out_last  out  1  marks bin NUM_BINS-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when readout completes
- row_cnt  out  11  rows completed this frame
- overrun_err  out  1  sticky, cleared on accepted start

Behaviour:
- Reset: state IDLE. All outputs 0, including counters.
- States: IDLE, CLEAR, ACQ, DRAIN, READOUT.
- IDLE -> CLEAR on start. start is ignored in every other state.
- CLEAR:
  - clr_we=1 for exactly NUM_BINS cycles; clr_addr runs 0..NUM_BINS-1.
  - Enters ACQ the cycle after the last write.
- ACQ:
  - chan_ena=4'hF and acc_en=1.
  - Per-channel pixel counters (0..ROW_PIXELS/4) increment on pix_valid.
  - Row completes in the cycle where all four counters reach ROW_PIXELS/4, counting that cycle's strobes.
  - On row completion: row_cnt increments and counters reset to 0.
  - A strobe on a channel arriving in the completion cycle, after that channel is already full, counts as 1 toward the next row.
  - A strobe on a full channel outside a completion cycle sets overrun_err and is not counted.
  - When row_cnt reaches the sampled row count, go to DRAIN.
- DRAIN:
  - chan_ena=0; acc_en stays 1.
  - Quiet counter resets on any pix_valid.
  - Goes to READOUT after DRAIN_CYC consecutive cycles with pix_valid==0.
- READOUT:
  - acc_en=0. Reads addresses 0..NUM_BINS-1 in order.
  - out_valid/out_ready follow stream semantics: out_data and out_last stay stable while out_valid && !out_ready.
  - No bin dropped or duplicated.
  - Sustains 1 bin/cycle with out_ready held high.
  - First out_valid no later than 2 cycles after READOUT entry.
  - rd_en is issued only when buffer space exists; a 2-entry skid is sufficient.
  - After the handshake of the out_last beat: done=1 for one cycle, state -> IDLE.
- abort (any non-IDLE state):
  - Next state IDLE; chan_ena, acc_en, clr_we, out_valid drop the following cycle.
  - Skid buffer is flushed. No done pulse. row_cnt is held for debug.
- Simultaneous start and abort in IDLE: abort wins, start is ignored.
- Reset mid-operation: immediate return to reset values.
- row_cnt is 11-bit; the maximum configured count is 2047. The frame ends on equality, so no wrap.

Decomposition:
- Package spectro_pkg holds:
  - acq_state_t enum
  - constants NUM_CH=4 and the default values of NUM_BINS, ROW_PIXELS and BIN_DATA_W
- Sub-module spectro_row_tracker: the four pixel counters plus completion and overrun logic, exposing a row_done pulse.

Test Plan:
- NUM_BINS=8, ROW_PIXELS=8, num_rows_cfg=2; 2 pixels per channel per row, then DRAIN_CYC quiet cycles, out_ready=1 -> clr_we for 8 cycles, row_cnt 1 then 2, 8 beats with out_last on the 8th, done pulse, busy drops.
- Readout with out_ready toggling 1010... and a 5-cycle stall mid-stream -> data stable during stalls, beats in address order 0..7, none duplicated.
- Channel 2 gives a 3rd pixel before channels 0/1/3 finish the row -> overrun_err=1 and row still completes on the 2nd pixel of the others. Next start clears overrun_err.
- Channels 0..2 full; channel 3's last pixel arrives together with channel 0's next pixel -> row_cnt increments, channel 0 counter = 1, no overrun.
- abort asserted in ACQ after 1 row -> next cycle chan_ena=0, state IDLE, no done. A subsequent start begins a fresh CLEAR.
- start pulsed during READOUT, and num_rows_cfg=0 -> start ignored; a later frame with cfg 0 completes after 1 row.
